// File: rtl/udp_tx_framer.sv
// UDP transmit framer: emits an 8-byte UDP header followed by payload_len
// pass-through payload bytes on a valid/ready byte stream.
module udp_tx_framer #(
    parameter int MAX_PAYLOAD = 1472
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        start_ready,
    input  logic [15:0] src_port,
    input  logic [15:0] dst_port,
    input  logic [15:0] payload_len,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    input  logic        in_last,
    output logic        in_ready,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_last,
    output logic        busy,
    output logic        len_err
);

    typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD} state_t;

    typedef struct packed {
        logic [15:0] src;
        logic [15:0] dst;
        logic [15:0] plen;
        logic [15:0] udp_len;
    } cmd_t;

    state_t      state, state_nxt;
    cmd_t        cmd;
    logic [2:0]  hdr_idx;
    logic [15:0] pay_cnt;
    logic        accept, reject, xfer, hdr_last, pay_last;

    assign accept   = start & start_ready & (payload_len <= 16'(MAX_PAYLOAD));
    assign reject   = start & start_ready & (payload_len >  16'(MAX_PAYLOAD));
    assign xfer     = out_valid & out_ready;
    assign hdr_last = (hdr_idx == 3'd7);
    // plen is never 0 while in PAYLOAD, so the subtraction cannot wrap there
    assign pay_last = (pay_cnt == cmd.plen - 16'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = HEADER;
            HEADER:  if (xfer && hdr_last) state_nxt = (cmd.plen != 16'd0) ? PAYLOAD : IDLE;
            PAYLOAD: if (xfer && pay_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        start_ready = 1'b0;
        in_ready    = 1'b0;
        out_data    = 8'h00;
        out_valid   = 1'b0;
        out_last    = 1'b0;
        busy        = 1'b0;
        case (state)
            IDLE: start_ready = 1'b1;
            HEADER: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_last  = hdr_last && (cmd.plen == 16'd0);
                case (hdr_idx)
                    3'd0:    out_data = cmd.src[15:8];
                    3'd1:    out_data = cmd.src[7:0];
                    3'd2:    out_data = cmd.dst[15:8];
                    3'd3:    out_data = cmd.dst[7:0];
                    3'd4:    out_data = cmd.udp_len[15:8];
                    3'd5:    out_data = cmd.udp_len[7:0];
                    default: out_data = 8'h00;
                endcase
            end
            PAYLOAD: begin
                busy      = 1'b1;
                out_data  = in_data;
                out_valid = in_valid;
                in_ready  = out_ready;
                out_last  = pay_last;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd     <= '0;
            hdr_idx <= 3'd0;
            pay_cnt <= 16'd0;
            len_err <= 1'b0;
        end else begin
            // in_last is only cross-checked against our own count, never used to end the frame
            len_err <= reject | ((state == PAYLOAD) && xfer && (in_last != out_last));
            if (accept) begin
                cmd.src     <= src_port;
                cmd.dst     <= dst_port;
                cmd.plen    <= payload_len;
                cmd.udp_len <= payload_len + 16'd8;
                hdr_idx     <= 3'd0;
                pay_cnt     <= 16'd0;
            end else if (xfer && state == HEADER) begin
                hdr_idx <= hdr_idx + 3'd1;
            end else if (xfer && state == PAYLOAD && !pay_last) begin
                pay_cnt <= pay_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_udp_tx_framer.sv
// Scoreboard bench for udp_tx_framer: expected bytes queued at command issue,
// popped and compared as the framer transfers them.
module tb_udp_tx_framer;
    localparam int MAXP = 1472;

    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic [15:0] src_port = 16'h0, dst_port = 16'h0, payload_len = 16'h0;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b1;
    logic        start_ready, in_ready, out_valid, out_last, busy, len_err;
    logic [7:0]  out_data;

    udp_tx_framer #(.MAX_PAYLOAD(MAXP)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .start_ready(start_ready),
        .src_port(src_port), .dst_port(dst_port), .payload_len(payload_len),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .busy(busy), .len_err(len_err)
    );

    always #5 clk = ~clk;

    int         n_cmp = 0, n_mis = 0;
    logic [8:0] exp_q[$];
    logic [8:0] src_q[$];
    bit         bp = 0, src_hs = 0, in_ready_seen = 0, prev_busy = 0, prev_stall = 0;
    logic [7:0] prev_data = 8'h00;
    int         cyc = 0, xfer_cnt = 0, busy_xfer = 0, last_cnt = 0, err_cyc = 0;
    int         last_cyc = 0, hdr_cyc = 0;

    task automatic monitor();
        logic [8:0] e;
        forever begin
            @(negedge clk);
            cyc++;
            src_hs = in_valid && in_ready;
            if (len_err) err_cyc++;
            if (in_ready) in_ready_seen = 1;
            if (busy && !prev_busy) hdr_cyc = cyc;
            if (prev_stall) begin
                n_cmp++;
                if (out_valid !== 1'b1 || out_data !== prev_data) begin
                    n_mis++;
                    $display("FAIL stall_hold: got v=%b d=%h, required v=1 d=%h", out_valid, out_data, prev_data);
                end
            end
            if (out_valid && out_ready) begin
                xfer_cnt++;
                if (busy) busy_xfer++;
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_mis++;
                    $display("FAIL unexpected_byte: got last=%b d=%h, required none", out_last, out_data);
                end else begin
                    e = exp_q.pop_front();
                    if ({out_last, out_data} !== e) begin
                        n_mis++;
                        $display("FAIL out_byte: got last=%b d=%h, required last=%b d=%h", out_last, out_data, e[8], e[7:0]);
                    end
                end
                if (out_last) begin last_cnt++; last_cyc = cyc; end
            end
            prev_stall = rst_n && out_valid && !out_ready;
            prev_data  = out_data;
            prev_busy  = busy;
        end
    endtask

    // payload source plus downstream ready; holds each byte until accepted
    task automatic driver();
        forever begin
            @(posedge clk);
            #1;
            out_ready = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (src_hs && src_q.size() > 0) void'(src_q.pop_front());
            src_hs = 0;
            if (!in_valid || src_hs_taken()) begin
                if (src_q.size() > 0 && (!bp || $urandom_range(0, 2) != 0)) begin
                    in_valid = 1'b1;
                    {in_last, in_data} = src_q[0];
                end else begin
                    in_valid = 1'b0;
                    in_last  = 1'b0;
                end
            end
        end
    endtask

    bit hs_flag = 0;
    function automatic bit src_hs_taken();
        return hs_flag;
    endfunction

    task automatic push_frame(input logic [15:0] s, input logic [15:0] d, input int len,
                              input int lastpos, input bit fixed);
        logic [15:0] ul;
        logic [7:0]  hb[8];
        logic [7:0]  b;
        ul = 16'(len + 8);
        hb[0] = s[15:8];  hb[1] = s[7:0];  hb[2] = d[15:8];  hb[3] = d[7:0];
        hb[4] = ul[15:8]; hb[5] = ul[7:0]; hb[6] = 8'h00;    hb[7] = 8'h00;
        for (int i = 0; i < 8; i++) exp_q.push_back({(len == 0 && i == 7), hb[i]});
        for (int i = 0; i < len; i++) begin
            b = fixed ? 8'(8'hAA + i * 8'h11) : 8'($urandom);
            src_q.push_back({(i == lastpos), b});
            exp_q.push_back({(i == len - 1), b});
        end
    endtask

    task automatic wait_ready();
        int t = 0;
        @(posedge clk); #2;
        while (!start_ready && t < 3000) begin @(posedge clk); #2; t++; end
        n_cmp++;
        if (t >= 3000) begin n_mis++; $display("FAIL wait_ready: got timeout, required start_ready"); end
    endtask

    task automatic issue(input logic [15:0] s, input logic [15:0] d, input int len,
                         input int lastpos, input bit fixed);
        wait_ready();
        start = 1'b1; src_port = s; dst_port = d; payload_len = 16'(len);
        if (len <= MAXP) push_frame(s, d, len, lastpos, fixed);
        @(posedge clk); #2;
        start = 1'b0;
    endtask

    task automatic wait_done();
        int t = 0;
        while ((exp_q.size() != 0 || !start_ready) && t < 5000) begin @(posedge clk); #2; t++; end
        n_cmp++;
        if (t >= 5000) begin n_mis++; $display("FAIL wait_done: got %0d bytes pending, required 0", exp_q.size()); end
        @(negedge clk); @(negedge clk);
    endtask

    task automatic check_int(input string name, input int got, input int req);
        n_cmp++;
        if (got !== req) begin n_mis++; $display("FAIL %s: got %0d, required %0d", name, got, req); end
    endtask

    task automatic check_reset_outputs(input string name);
        n_cmp++;
        if ({start_ready, in_ready, out_valid, out_last, busy, len_err, out_data} !== {6'b100000, 8'h00}) begin
            n_mis++;
            $display("FAIL %s: got sr=%b ir=%b ov=%b ol=%b busy=%b le=%b d=%h, required sr=1 others 0",
                     name, start_ready, in_ready, out_valid, out_last, busy, len_err, out_data);
        end
    endtask

    task automatic test_reset();
        #12;
        check_reset_outputs("reset_values");
        @(posedge clk); #2 rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("post_reset_idle");
    endtask

    task automatic test_basic();
        int e0 = err_cyc, b0 = busy_xfer, l0 = last_cnt;
        issue(16'h1234, 16'h0050, 4, 3, 1);
        wait_done();
        check_int("basic_busy_xfers", busy_xfer - b0, 12);
        check_int("basic_last_cnt", last_cnt - l0, 1);
        check_int("basic_len_err", err_cyc - e0, 0);
        check_int("basic_start_ready", int'(start_ready), 1);
    endtask

    task automatic test_backpressure();
        int e0 = err_cyc, x0 = xfer_cnt;
        bp = 1;
        issue(16'h1234, 16'h0050, 4, 3, 1);
        wait_done();
        issue(16'hA5C3, 16'h0F0F, 37, 36, 0);
        wait_done();
        bp = 0;
        check_int("bp_xfers", xfer_cnt - x0, 12 + 45);
        check_int("bp_len_err", err_cyc - e0, 0);
    endtask

    task automatic test_zero_payload();
        int x0 = xfer_cnt, l0 = last_cnt;
        in_ready_seen = 0;
        issue(16'h0102, 16'h0304, 0, 0, 1);
        wait_done();
        check_int("zero_xfers", xfer_cnt - x0, 8);
        check_int("zero_last_cnt", last_cnt - l0, 1);
        check_int("zero_in_ready_seen", int'(in_ready_seen), 0);
    endtask

    task automatic test_oversize_mismatch();
        int e0, x0;
        wait_ready();
        x0 = xfer_cnt;
        start = 1'b1; payload_len = 16'd1473;
        @(posedge clk); #2 start = 1'b0;
        @(negedge clk);
        check_int("over_len_err", int'(len_err), 1);
        check_int("over_busy", int'(busy), 0);
        check_int("over_start_ready", int'(start_ready), 1);
        @(negedge clk);
        check_int("over_len_err_pulse", int'(len_err), 0);
        check_int("over_no_xfer", xfer_cnt - x0, 0);
        e0 = err_cyc; x0 = xfer_cnt;
        issue(16'h5555, 16'hAAAA, 3, 1, 0);
        wait_done();
        check_int("mismatch_len_err", err_cyc - e0, 2);
        check_int("mismatch_xfers", xfer_cnt - x0, 11);
        e0 = err_cyc;
        issue(16'h1111, 16'h2222, MAXP, MAXP - 1, 0);
        wait_done();
        check_int("maxlen_len_err", err_cyc - e0, 0);
    endtask

    task automatic test_back_to_back();
        int t = 0, l0, a_last;
        wait_ready();
        start = 1'b1; src_port = 16'hC0DE; dst_port = 16'h0007; payload_len = 16'd2;
        push_frame(16'hC0DE, 16'h0007, 2, 1, 0);
        @(posedge clk); #2;
        l0 = last_cnt;
        src_port = 16'hFACE; dst_port = 16'h0009; payload_len = 16'd3;
        push_frame(16'hFACE, 16'h0009, 3, 2, 0);
        while (last_cnt == l0 && t < 200) begin @(posedge clk); #2; t++; end
        a_last = last_cyc;
        while (!busy && t < 200) begin @(posedge clk); #2; t++; end
        start = 1'b0;
        wait_done();
        check_int("b2b_timeout", int'(t < 200), 1);
        check_int("b2b_gap", hdr_cyc - a_last, 2);
        check_int("b2b_frames", last_cnt - l0, 2);
    endtask

    task automatic test_reset_mid();
        int t = 0, x0, l0;
        x0 = xfer_cnt;
        issue(16'hBEEF, 16'h1111, 4, 3, 0);
        while (xfer_cnt - x0 < 9 && t < 200) begin @(posedge clk); #2; t++; end
        l0 = last_cnt;
        #1 rst_n = 1'b0;
        #1 check_reset_outputs("reset_mid");
        exp_q.delete(); src_q.delete();
        in_valid = 1'b0; in_last = 1'b0;
        @(posedge clk); #2 rst_n = 1'b1;
        @(negedge clk);
        check_int("reset_mid_no_last", last_cnt - l0, 0);
        l0 = last_cnt; x0 = xfer_cnt;
        issue(16'h4321, 16'h8765, 5, 4, 0);
        wait_done();
        check_int("reset_recover_xfers", xfer_cnt - x0, 13);
        check_int("reset_recover_last", last_cnt - l0, 1);
    endtask

    initial begin
        fork
            monitor();
            driver();
        join_none
        test_reset();
        test_basic();
        test_backpressure();
        test_zero_payload();
        test_oversize_mismatch();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got no finish, required finish");
        $fatal(1, "watchdog");
    end

    // hs_flag mirrors the handshake seen at the last falling edge for the driver
    always @(negedge clk) hs_flag <= in_valid && in_ready;

endmodule

// File: doc/udp_tx_framer.md
Name: udp_tx_framer

Overview:
Transmit-side counterpart of the UDP parser's byte-count logic. On a start command, emits an 8-byte UDP header (src port, dst port, length, checksum) followed by exactly payload_len payload bytes. The block streams one byte per handshake on a valid/ready byte interface, and asserts out_last on the final byte from its own byte counter. It sits between the payload source and the IP/MAC transmit path.

Parameters:
MAX_PAYLOAD, 1472, largest accepted payload_len in bytes; larger requests are rejected.

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
start  in  1  start-command strobe; sampled only when start_ready=1
start_ready  out  1  high in IDLE; command accepted when start & start_ready
src_port  in  16  UDP source port, captured at command accept
dst_port  in  16  UDP destination port, captured at command accept
payload_len  in  16  payload byte count, captured at command accept
in_data  in  8  payload byte
in_valid  in  1  payload byte valid
in_last  in  1  source's end-of-payload marker; checked only, not used for framing
in_ready  out  1  payload byte accepted when in_valid & in_ready
out_data  out  8  framed byte
out_valid  out  1  framed byte valid
out_ready  in  1  downstream ready
out_last  out  1  final byte of datagram, qualified by out_valid
busy  out  1  high in HEADER or PAYLOAD
len_err  out  1  one-cycle pulse on a length mismatch or rejected command

Behaviour:
- Reset, asynchronous: state=IDLE, all counters and captured fields = 0, start_ready=1, in_ready=0, out_valid=0, out_last=0, busy=0, len_err=0, out_data=0.
- States: IDLE, HEADER, PAYLOAD.
- IDLE:
  - On start, with payload_len <= MAX_PAYLOAD: capture the fields, set udp_len = payload_len + 8 (16-bit, no overflow possible given MAX_PAYLOAD), clear hdr_idx=0 and pay_cnt=0, go to HEADER next cycle.
  - On start, with payload_len > MAX_PAYLOAD: stay in IDLE and pulse len_err for 1 cycle.
- HEADER:
  - out_valid=1; in_ready=0.
  - out_data by hdr_idx, big-endian: 0 src[15:8], 1 src[7:0], 2 dst[15:8], 3 dst[7:0], 4 udp_len[15:8], 5 udp_len[7:0], 6 8'h00, 7 8'h00 (checksum fixed at 0).
  - hdr_idx advances only on out_valid & out_ready.
  - out_data holds stable while out_ready=0.
  - On accepted byte 7: go to PAYLOAD if payload_len != 0, else go to IDLE.
  - out_last=1 on byte 7 only when payload_len == 0.
- PAYLOAD:
  - Pass-through with zero latency: out_data=in_data, out_valid=in_valid, in_ready=out_ready.
  - out_last = (pay_cnt == payload_len-1).
  - pay_cnt increments on each transfer.
  - The transfer with out_last=1 returns the block to IDLE on the next cycle.
- Length check:
  - On every payload transfer, if in_last != out_last, pulse len_err on the following cycle.
  - Framing is unaffected: the block always emits exactly payload_len bytes, ignoring an early in_last and ending even if in_last has not been seen.
- start is ignored while busy. start_ready is low in HEADER and PAYLOAD.
- A new command may be accepted the cycle after the last transfer, giving back-to-back datagrams with no idle gap beyond that one IDLE cycle.
- Reset mid-datagram: immediate return to reset values. The partial frame is abandoned without out_last.
- Downstream stalls of any length are lossless. No byte may be duplicated or skipped.
- Counters are 16-bit. pay_cnt never exceeds payload_len-1.

Test Plan:
- Basic frame: src=0x1234, dst=0x0050, len=4, payload AA BB CC DD, out_ready=1 -> out = 12 34 00 50 00 0C 00 00 AA BB CC DD; out_last only on DD; busy high for 12 transfers, then start_ready=1.
- Backpressure: same frame with out_ready toggled 1-0-0-1 pseudo-randomly and in_valid gaps -> identical 12-byte sequence; out_data stable while stalled; no dropped or duplicated bytes.
- Zero payload: len=0 -> 8 bytes, length field 00 08; out_last on 8th byte; in_ready never asserted.
- Oversize and length mismatch:
  - len=1473 -> no busy, len_err pulse, start_ready stays 1.
  - len=3 with in_last on the 2nd byte -> len_err pulse; 3 payload bytes still emitted; out_last on the 3rd.
- Back-to-back and reset:
  - start held high -> second header begins one cycle after the first frame's last transfer.
  - rst_n low during payload byte 2 -> all outputs at reset values immediately; the next command frames correctly.
